mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports M_PC and M_Ins, input, 32 bits each: PC and instruction currently in the M stage.
REQ-004 SHALL have port M_ALU_Y, input, 32 bits: ALU result, used as memory byte address and as the ALU write-back value.
REQ-005 SHALL have port M_rt_data, input, 32 bits: rt value as latched by the E stage.
REQ-006 SHALL have port M_rt_fw, input, 32 bits: rt value after M-stage forwarding; the only source of store data.
REQ-007 SHALL have port M_branchTrue, input, 1 bit: branch-taken flag, passed through to W.
REQ-008 SHALL have port M_rt, output, 5 bits: Ins[20:16], so the hazard unit can select M_rt_fw.
REQ-009 SHALL have port M_GRF_WA, output, 5 bits: destination register of the M-stage instruction; 0 if none.
REQ-010 SHALL have port M_GRF_WD, output, 32 bits: forwardable M-stage result.
REQ-011 SHALL have port M_Tnew, output, 2 bits: cycles until the M-stage result is available.
REQ-012 SHALL have ports W_PC, W_Ins, W_ALU_Y and W_DM_RD, output reg, 32 bits each: W-stage pipeline registers.
REQ-013 SHALL have port W_branchTrue, output reg, 1 bit: W-stage copy of M_branchTrue.

Function
REQ-014 SHALL decode from M_Ins opcode (op) = Ins[31:26] and funct = Ins[5:0] as follows:
- lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24
- sw 0x2B, sh 0x29, sb 0x28
- R-type op 0x00 with funct addu 0x21, subu 0x23, jr 0x08
- ori 0x0D, lui 0x0F, jal 0x03, beq 0x04
REQ-015 SHALL contain a 4096x32 data memory, word index = M_ALU_Y[13:2]; address bits 31:14 are ignored.
REQ-016 SHALL perform stores on the rising edge of clk when reset=0, with no stall or handshake:
- sw writes the whole word.
- sh writes halfword M_ALU_Y[1] (0 = bits 15:0, 1 = bits 31:16) with M_rt_fw[15:0].
- sb writes byte lane M_ALU_Y[1:0] (lane n = bits 8n+7:8n) with M_rt_fw[7:0].
- Unwritten lanes are preserved.
REQ-017 SHALL suppress a misaligned store (sw with A[1:0]≠0, sh with A[0]=1): no memory change.
REQ-018 SHALL read the data memory combinationally (read data DR) and shape it as follows:
- lw: DR as-is.
- lh/lhu: the selected halfword, sign-/zero-extended.
- lb/lbu: the selected byte, sign-/zero-extended.
- Misaligned load: 0.
- Non-load: 0.
REQ-019 SHALL register the shaped value into W_DM_RD at each clock edge.
REQ-020 SHALL drive M_GRF_WA as follows:
- addu/subu: rd = Ins[15:11].
- ori/lui/loads: rt.
- jal: 31.
- All others: 0.
REQ-021 SHALL drive M_GRF_WD as follows:
- addu/subu/ori/lui: M_ALU_Y.
- jal: M_PC+8.
- Loads and all others: 0.
REQ-022 SHALL drive M_Tnew = 1 for loads and 0 otherwise.
REQ-023 SHALL, on each non-reset edge, load W_PC, W_Ins, W_ALU_Y and W_branchTrue from the corresponding M_ inputs, giving a latency of 1 cycle.
REQ-024 SHALL give read-during-write to the same word in the same cycle the old contents; a store followed next cycle by a load returns the new data.
REQ-025 SHALL treat M_Ins=0 (bubble) as a nop: no store, M_GRF_WA=0, M_Tnew=0.

Reset
REQ-026 SHALL, while reset=1 at an edge, clear W_PC, W_Ins, W_ALU_Y, W_DM_RD and W_branchTrue to 0, clear all 4096 memory words to 0, and inhibit any store presented that cycle.
REQ-027 SHALL accept new stores on the first edge after reset deasserts; an in-flight store coincident with reset is lost.

Verification
REQ-028 SHALL be verified with the scenario: sw M_ALU_Y=0x10, M_rt_fw=0x12345678; next cycle lw 0x10 -> W_DM_RD=0x12345678.
REQ-029 SHALL be verified with the scenario: sb 0x11 data 0xAB over word 0x12345678, then lb 0x11 -> W_DM_RD=0xFFFFFFAB; lbu 0x11 -> 0x000000AB; lw 0x10 -> 0x1234AB78.
REQ-030 SHALL be verified with the scenario: sh 0x12 data 0x8001, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; sh 0x13 -> memory unchanged.
REQ-031 SHALL be verified with the scenario: jal with M_PC=0x3000 -> M_GRF_WA=31, M_GRF_WD=0x3008, M_Tnew=0; lw rt=5 -> M_GRF_WA=5, M_Tnew=1.
REQ-032 SHALL be verified with the scenario: sw in M while reset=1 -> word stays 0; all W_ outputs 0 after the edge.
REQ-033 SHALL be verified with the scenario: M_Ins=0 with M_ALU_Y=0x10 and M_rt_fw=0xFFFFFFFF -> memory unchanged; M_GRF_WA=0.

Source files
------------

// File: rtl/mem_stage.sv
// Purpose : M stage of the 5-stage MIPS pipeline: 4096x32 data memory with
//           byte/halfword/word stores, shaped loads, forwarding outputs and
//           the M->W pipeline registers.
// Latency : W_* registers load 1 cycle after the M inputs. M_GRF_*, M_Tnew
//           and M_rt are combinational. Stores commit on the same edge.
// Backpressure: none. One instruction is accepted every cycle, with no stall.
// Ports   : clk, reset (sync, active-high)
//           M_PC, M_Ins, M_ALU_Y (address / ALU result), M_rt_data, M_rt_fw
//           (store data), M_branchTrue
//           -> M_rt, M_GRF_WA, M_GRF_WD, M_Tnew (hazard/forwarding)
//           -> W_PC, W_Ins, W_ALU_Y, W_DM_RD, W_branchTrue (W pipeline regs)
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_Ins,
  input  logic [31:0] M_ALU_Y,
  input  logic [31:0] M_rt_data,
  input  logic [31:0] M_rt_fw,
  input  logic        M_branchTrue,
  output logic [4:0]  M_rt,
  output logic [4:0]  M_GRF_WA,
  output logic [31:0] M_GRF_WD,
  output logic [1:0]  M_Tnew,
  output logic [31:0] W_PC,
  output logic [31:0] W_Ins,
  output logic [31:0] W_ALU_Y,
  output logic [31:0] W_DM_RD,
  output logic        W_branchTrue
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;
  // R-type function codes
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam int unsigned DM_WORDS = 4096;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [5:0] op;
  logic [5:0] funct;
  logic       is_lw, is_lh, is_lhu, is_lb, is_lbu, is_load;
  logic       is_sw, is_sh, is_sb;
  logic       is_addu, is_subu, is_ori, is_lui, is_jal;

  assign op    = M_Ins[31:26];
  assign funct = M_Ins[5:0];

  assign is_lw   = (op == OP_LW);
  assign is_lh   = (op == OP_LH);
  assign is_lhu  = (op == OP_LHU);
  assign is_lb   = (op == OP_LB);
  assign is_lbu  = (op == OP_LBU);
  assign is_load = is_lw | is_lh | is_lhu | is_lb | is_lbu;

  assign is_sw   = (op == OP_SW);
  assign is_sh   = (op == OP_SH);
  assign is_sb   = (op == OP_SB);

  // A bubble (M_Ins == 0) decodes as R-type funct 0, which matches nothing.
  assign is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_jal  = (op == OP_JAL);

  assign M_rt = M_Ins[20:16];

  // ---------------------------------------------------------------------
  // Data memory addressing. Only bits 13:0 of the address are decoded;
  // the upper bits alias onto the same 16 KiB.
  // ---------------------------------------------------------------------
  logic [11:0] word_idx;
  logic [1:0]  byte_off;

  assign word_idx = M_ALU_Y[13:2];
  assign byte_off = M_ALU_Y[1:0];

  logic [31:0] dm [DM_WORDS];

  // ---------------------------------------------------------------------
  // Store byte enables and lane-replicated write data. Misaligned sw/sh
  // produce an all-zero enable, so they leave memory untouched.
  // ---------------------------------------------------------------------
  logic [3:0]  st_be;
  logic [31:0] st_dat;

  always_comb begin
    st_be  = 4'b0000;
    st_dat = M_rt_fw;
    if (is_sw) begin
      st_dat = M_rt_fw;
      if (byte_off == 2'b00)
        st_be = 4'b1111;
    end else if (is_sh) begin
      st_dat = {2{M_rt_fw[15:0]}};
      if (!byte_off[0])
        st_be = byte_off[1] ? 4'b1100 : 4'b0011;
    end else if (is_sb) begin
      st_dat = {4{M_rt_fw[7:0]}};
      st_be  = 4'b0001 << byte_off;
    end
  end

  // Memory write port. Reset clears every word and blocks the store
  // presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        dm[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b])
          dm[word_idx][8*b +: 8] <= st_dat[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Combinational read and load shaping. Because the write above is an
  // edge-triggered update, a load in the same cycle as a store to the same
  // word sees the old contents; the next cycle sees the new ones.
  // ---------------------------------------------------------------------
  logic [31:0] dm_rd;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] ld_val;

  assign dm_rd   = dm[word_idx];
  assign rd_half = byte_off[1] ? dm_rd[31:16] : dm_rd[15:0];
  assign rd_byte = dm_rd[{byte_off, 3'b000} +: 8];

  always_comb begin
    ld_val = '0;
    if (is_lw) begin
      if (byte_off == 2'b00)
        ld_val = dm_rd;
    end else if (is_lh || is_lhu) begin
      if (!byte_off[0])
        ld_val = is_lh ? {{16{rd_half[15]}}, rd_half} : {16'h0000, rd_half};
    end else if (is_lb || is_lbu) begin
      ld_val = is_lb ? {{24{rd_byte[7]}}, rd_byte} : {24'h000000, rd_byte};
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding / hazard information for the M-stage instruction.
  // Loads report a destination but no data: their value only exists in W.
  // ---------------------------------------------------------------------
  always_comb begin
    M_GRF_WA = 5'd0;
    if (is_addu || is_subu)
      M_GRF_WA = M_Ins[15:11];
    else if (is_ori || is_lui || is_load)
      M_GRF_WA = M_Ins[20:16];
    else if (is_jal)
      M_GRF_WA = 5'd31;
  end

  always_comb begin
    M_GRF_WD = '0;
    if (is_addu || is_subu || is_ori || is_lui)
      M_GRF_WD = M_ALU_Y;
    else if (is_jal)
      M_GRF_WD = M_PC + 32'd8;
  end

  assign M_Tnew = is_load ? 2'd1 : 2'd0;

  // ---------------------------------------------------------------------
  // M -> W pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      W_PC         <= '0;
      W_Ins        <= '0;
      W_ALU_Y      <= '0;
      W_DM_RD      <= '0;
      W_branchTrue <= 1'b0;
    end else begin
      W_PC         <= M_PC;
      W_Ins        <= M_Ins;
      W_ALU_Y      <= M_ALU_Y;
      W_DM_RD      <= ld_val;
      W_branchTrue <= M_branchTrue;
    end
  end

  // The E-stage rt copy is superseded by the forwarded value for stores;
  // fields not used by this stage's decode are collected here.
  logic unused_bits;
  assign unused_bits = ^{M_rt_data, M_ALU_Y[31:14], M_Ins[25:21], M_Ins[10:6]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] M_PC = '0, M_Ins = '0, M_ALU_Y = '0, M_rt_data = '0, M_rt_fw = '0;
  logic        M_branchTrue = 1'b0;
  logic [4:0]  M_rt, M_GRF_WA;
  logic [31:0] M_GRF_WD;
  logic [1:0]  M_Tnew;
  logic [31:0] W_PC, W_Ins, W_ALU_Y, W_DM_RD;
  logic        W_branchTrue;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .M_PC(M_PC), .M_Ins(M_Ins), .M_ALU_Y(M_ALU_Y),
    .M_rt_data(M_rt_data), .M_rt_fw(M_rt_fw), .M_branchTrue(M_branchTrue),
    .M_rt(M_rt), .M_GRF_WA(M_GRF_WA), .M_GRF_WD(M_GRF_WD), .M_Tnew(M_Tnew),
    .W_PC(W_PC), .W_Ins(W_Ins), .W_ALU_Y(W_ALU_Y), .W_DM_RD(W_DM_RD),
    .W_branchTrue(W_branchTrue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: byte-addressed memory semantics with shifts/masks.
  // ------------------------------------------------------------------
  logic [31:0] ref_mem [4096];
  logic [31:0] exp_pc, exp_ins, exp_y, exp_rd;
  logic        exp_bt;
  bit          chk_en = 0;

  function automatic logic [31:0] model_load(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [5:0]  op;
    int unsigned off;
    logic [31:0] v;
    op  = ins[31:26];
    off = a % 4;
    v   = word >> (8 * off);
    case (op)
      6'h23: return (off == 0) ? word : 32'h0;
      6'h21: begin
        if (off % 2 != 0) return 32'h0;
        v = v & 32'hFFFF;
        return (v >= 32'h8000) ? v + 32'hFFFF0000 : v;
      end
      6'h25: return (off % 2 != 0) ? 32'h0 : (v & 32'hFFFF);
      6'h20: begin
        v = v & 32'hFF;
        return (v >= 32'h80) ? v + 32'hFFFFFF00 : v;
      end
      6'h24: return v & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] word);
    int unsigned off;
    logic [31:0] mask;
    off = a % 4;
    case (ins[31:26])
      6'h2B: return (off == 0) ? d : word;
      6'h29: begin
        if (off % 2 != 0) return word;
        mask = 32'hFFFF << (8 * off);
        return (word & ~mask) | ((d & 32'hFFFF) << (8 * off));
      end
      6'h28: begin
        mask = 32'hFF << (8 * off);
        return (word & ~mask) | ((d & 32'hFF) << (8 * off));
      end
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_pc = 0; exp_ins = 0; exp_y = 0; exp_rd = 0; exp_bt = 0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      chk_en = 1;
    end else begin
      int unsigned idx;
      idx     = (M_ALU_Y / 4) % 4096;
      exp_pc  = M_PC;
      exp_ins = M_Ins;
      exp_y   = M_ALU_Y;
      exp_bt  = M_branchTrue;
      exp_rd  = model_load(M_Ins, M_ALU_Y, ref_mem[idx]);
      ref_mem[idx] = model_store(M_Ins, M_ALU_Y, M_rt_fw, ref_mem[idx]);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0]  op, fn;
      bit          ld, rr, imm;
      logic [31:0] e_wa, e_wd, e_tn;
      op  = M_Ins[31:26];
      fn  = M_Ins[5:0];
      ld  = (op == 6'h23) || (op == 6'h21) || (op == 6'h25) || (op == 6'h20) || (op == 6'h24);
      rr  = (op == 6'h00) && ((fn == 6'h21) || (fn == 6'h23));
      imm = (op == 6'h0D) || (op == 6'h0F);
      e_wa = rr ? {27'd0, M_Ins[15:11]} : (ld || imm) ? {27'd0, M_Ins[20:16]} :
             (op == 6'h03) ? 32'd31 : 32'd0;
      e_wd = (rr || imm) ? M_ALU_Y : (op == 6'h03) ? M_PC + 32'd8 : 32'd0;
      e_tn = ld ? 32'd1 : 32'd0;
      chk("M_rt", {27'd0, M_rt}, {27'd0, M_Ins[20:16]});
      chk("M_GRF_WA", {27'd0, M_GRF_WA}, e_wa);
      chk("M_GRF_WD", M_GRF_WD, e_wd);
      chk("M_Tnew", {30'd0, M_Tnew}, e_tn);
      chk("W_PC", W_PC, exp_pc);
      chk("W_Ins", W_Ins, exp_ins);
      chk("W_ALU_Y", W_ALU_Y, exp_y);
      chk("W_DM_RD", W_DM_RD, exp_rd);
      chk("W_branchTrue", {31'd0, W_branchTrue}, {31'd0, exp_bt});
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  logic [31:0] cur_pc = 32'h0000_3000;

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0010};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  task automatic run(input logic rst, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] fw, input logic bt);
    @(posedge clk);
    #1;
    reset        = rst;
    M_Ins        = ins;
    M_ALU_Y      = a;
    M_rt_fw      = fw;
    M_rt_data    = fw ^ 32'h5A5A_5A5A;
    M_branchTrue = bt;
    M_PC         = cur_pc;
    cur_pc       = cur_pc + 4;
    @(negedge clk);
  endtask

  localparam logic [31:0] NOP = 32'h0;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Store presented while reset is high must be dropped.
    cur_pc = 32'h100;
    run(1, i_ins(6'h2B, 5'd3), 32'h10, 32'hCAFE_F00D, 1'b1);
    run(0, i_ins(6'h23, 5'd5), 32'h10, 32'h0, 1'b0);
    chk("lit reset W_PC", W_PC, 32'h0);
    chk("lit reset W_Ins", W_Ins, 32'h0);
    chk("lit reset W_ALU_Y", W_ALU_Y, 32'h0);
    chk("lit reset W_branchTrue", {31'd0, W_branchTrue}, 32'h0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit sw-in-reset dropped", W_DM_RD, 32'h0);

    // sw / lw
    run(0, i_ins(6'h2B, 5'd3), 32'h10, 32'h1234_5678, 1'b0);
    run(0, i_ins(6'h23, 5'd5), 32'h10, 32'h0, 1'b0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit lw 0x10", W_DM_RD, 32'h1234_5678);

    // sb then byte/word loads
    run(0, i_ins(6'h28, 5'd3), 32'h11, 32'hFFFF_FFAB, 1'b0);
    run(0, i_ins(6'h20, 5'd6), 32'h11, 32'h0, 1'b0);
    run(0, i_ins(6'h24, 5'd7), 32'h11, 32'h0, 1'b0);
    chk("lit lb 0x11", W_DM_RD, 32'hFFFF_FFAB);
    run(0, i_ins(6'h23, 5'd8), 32'h10, 32'h0, 1'b0);
    chk("lit lbu 0x11", W_DM_RD, 32'h0000_00AB);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit lw after sb", W_DM_RD, 32'h1234_AB78);

    // sh, halfword loads, misaligned sh
    run(0, i_ins(6'h29, 5'd3), 32'h12, 32'h0000_8001, 1'b0);
    run(0, i_ins(6'h21, 5'd6), 32'h12, 32'h0, 1'b0);
    run(0, i_ins(6'h25, 5'd7), 32'h12, 32'h0, 1'b0);
    chk("lit lh 0x12", W_DM_RD, 32'hFFFF_8001);
    run(0, i_ins(6'h29, 5'd3), 32'h13, 32'h0000_5555, 1'b0);
    chk("lit lhu 0x12", W_DM_RD, 32'h0000_8001);
    run(0, i_ins(6'h23, 5'd8), 32'h10, 32'h0, 1'b0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit sh 0x13 suppressed", W_DM_RD, 32'h8001_AB78);

    // Misaligned sw and loads
    run(0, i_ins(6'h2B, 5'd3), 32'h12, 32'hDEAD_BEEF, 1'b0);
    run(0, i_ins(6'h23, 5'd8), 32'h11, 32'h0, 1'b0);
    run(0, i_ins(6'h21, 5'd8), 32'h13, 32'h0, 1'b0);
    chk("lit misaligned lw", W_DM_RD, 32'h0);
    run(0, i_ins(6'h23, 5'd8), 32'h10, 32'h0, 1'b0);
    chk("lit misaligned lh", W_DM_RD, 32'h0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit misaligned sw suppressed", W_DM_RD, 32'h8001_AB78);

    // Upper address bits alias onto the same word
    run(0, i_ins(6'h2B, 5'd3), 32'hFFFF_C020, 32'hA5A5_0F0F, 1'b0);
    run(0, i_ins(6'h23, 5'd9), 32'h0000_0020, 32'h0, 1'b0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit address alias", W_DM_RD, 32'hA5A5_0F0F);

    // jal / lw forwarding info
    cur_pc = 32'h3000;
    run(0, {6'h03, 26'h0000C00}, 32'h0, 32'h0, 1'b0);
    chk("lit jal WA", {27'd0, M_GRF_WA}, 32'd31);
    chk("lit jal WD", M_GRF_WD, 32'h3008);
    chk("lit jal Tnew", {30'd0, M_Tnew}, 32'd0);
    run(0, i_ins(6'h23, 5'd5), 32'h10, 32'h0, 1'b0);
    chk("lit lw WA", {27'd0, M_GRF_WA}, 32'd5);
    chk("lit lw Tnew", {30'd0, M_Tnew}, 32'd1);

    // ALU ops and branch flag through the model
    run(0, r_ins(5'd12, 6'h21), 32'h0000_1111, 32'h0, 1'b0);
    chk("lit addu WA", {27'd0, M_GRF_WA}, 32'd12);
    run(0, r_ins(5'd13, 6'h23), 32'hFFFF_FFFE, 32'h0, 1'b0);
    run(0, i_ins(6'h0D, 5'd14), 32'h0000_00F0, 32'h0, 1'b0);
    run(0, i_ins(6'h0F, 5'd15), 32'h0010_0000, 32'h0, 1'b0);
    run(0, i_ins(6'h04, 5'd2), 32'h0, 32'h0, 1'b1);
    run(0, r_ins(5'd0, 6'h08), 32'h0, 32'h0, 1'b0);
    chk("lit beq branchTrue", {31'd0, W_branchTrue}, 32'd1);

    // Bubble must not store
    run(0, NOP, 32'h10, 32'hFFFF_FFFF, 1'b0);
    chk("lit bubble WA", {27'd0, M_GRF_WA}, 32'd0);
    run(0, i_ins(6'h23, 5'd8), 32'h10, 32'h0, 1'b0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit bubble no store", W_DM_RD, 32'h8001_AB78);

    // Reset clears memory contents
    run(1, NOP, 32'h0, 32'h0, 1'b0);
    run(0, i_ins(6'h23, 5'd8), 32'h10, 32'h0, 1'b0);
    run(0, NOP, 32'h0, 32'h0, 1'b0);
    chk("lit memory cleared", W_DM_RD, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
